// File: rtl/trafficlight_pkg.sv
// trafficlight: shared lamp codes and controller state encoding.
// Imported by the controller RTL and its bench.
package trafficlight_pkg;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  typedef enum logic [1:0] {
    MAIN_GREEN,
    MAIN_YELLOW,
    SIDE_GREEN,
    SIDE_YELLOW
  } state_t;

endpackage

// File: rtl/trafficlight_if.sv
// trafficlight: lamp outputs and congestion input bundled for the
// roadside environment (sensor driver + lamp monitor).
interface trafficlight_if;

  logic [1:0] MR;
  logic [1:0] SR;
  logic       congdetector;

  modport master (
    output MR,
    output SR,
    input  congdetector
  );

  modport slave (
    input  MR,
    input  SR,
    output congdetector
  );

endinterface

// File: rtl/trafficlight_sec_tick_gen.sv
// trafficlight: free-running prescaler giving a 1-cycle tick
// once every CLK_HZ cycles.
module sec_tick_gen #(
  parameter int CLK_HZ = 100
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick  = (cnt_q == LAST);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/trafficlight.sv
// trafficlight: two-road intersection controller with one
// congestion-driven main-green extension per phase.
module trafficlight
  import trafficlight_pkg::*;
#(
  parameter int CLK_HZ       = 100,
  parameter int MAIN_GREEN_S = 60,
  parameter int CONG_EXT_S   = 30,
  parameter int YELLOW_S     = 3,
  parameter int SIDE_GREEN_S = 20
) (
  output logic [1:0] MR,
  output logic [1:0] SR,
  input  logic       congdetector,
  input  logic       rst,
  input  logic       clk
);

  localparam int EXT_S = MAIN_GREEN_S + CONG_EXT_S;
  localparam int CW    = $clog2(EXT_S + 1);

  localparam logic [CW-1:0] MG_LAST  = CW'(MAIN_GREEN_S - 1);
  localparam logic [CW-1:0] EXT_LAST = CW'(EXT_S - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(YELLOW_S - 1);
  localparam logic [CW-1:0] SG_LAST  = CW'(SIDE_GREEN_S - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] sec_q, sec_d;
  logic          cong_q, cong_d;
  logic          sync1_q, sync2_q;
  logic          tick;

  sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= congdetector;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MAIN_GREEN;
      sec_q   <= '0;
      cong_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      cong_q  <= cong_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sec_d   = tick ? sec_q + 1'b1 : sec_q;
    cong_d  = 1'b0;
    unique case (state_q)
      MAIN_GREEN: begin
        // a sighting on the base-expiry cycle still counts
        cong_d = cong_q | sync2_q;
        if (tick && ((sec_q == MG_LAST && !cong_d) ||
                     sec_q == EXT_LAST))
          state_d = MAIN_YELLOW;
      end
      MAIN_YELLOW:
        if (tick && sec_q == Y_LAST) state_d = SIDE_GREEN;
      SIDE_GREEN:
        if (tick && sec_q == SG_LAST) state_d = SIDE_YELLOW;
      SIDE_YELLOW:
        if (tick && sec_q == Y_LAST) state_d = MAIN_GREEN;
      default: state_d = MAIN_GREEN;
    endcase
    if (state_d != state_q) begin
      sec_d  = '0;
      cong_d = 1'b0;
    end
  end

  always_comb begin
    MR = RED;
    SR = RED;
    unique case (state_q)
      MAIN_GREEN:  MR = GREEN;
      MAIN_YELLOW: MR = YELLOW;
      SIDE_GREEN:  SR = GREEN;
      SIDE_YELLOW: SR = YELLOW;
      default: begin
        MR = RED;
        SR = RED;
      end
    endcase
  end

endmodule

// File: tb/tb_trafficlight.sv
// trafficlight bench: directed phase-edge checks at 100 cycles/s
// plus a per-cycle lamp legality watch.
module tb_trafficlight;
  import trafficlight_pkg::*;

  localparam logic [3:0] L_MG = {GREEN, RED};
  localparam logic [3:0] L_MY = {YELLOW, RED};
  localparam logic [3:0] L_SG = {RED, GREEN};
  localparam logic [3:0] L_SY = {RED, YELLOW};

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  trafficlight_if tl_if ();

  trafficlight dut (
    .MR           (tl_if.MR),
    .SR           (tl_if.SR),
    .congdetector (tl_if.congdetector),
    .rst          (rst),
    .clk          (clk)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [3:0] got,
                     logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] lamps();
    return {tl_if.MR, tl_if.SR};
  endfunction

  function automatic logic legal();
    return tl_if.MR != 2'b11 && tl_if.SR != 2'b11 &&
           (tl_if.MR == RED || tl_if.SR == RED);
  endfunction

  always @(negedge clk)
    chk("legal", {3'b000, legal()}, 4'h1);

  task automatic do_reset();
    rst = 1'b0;
    tl_if.congdetector = 1'b0;
    #1 chk("rst_lamps", lamps(), L_MG);
    repeat (3) @(posedge clk);
    #1 chk("rst_hold", lamps(), L_MG);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic step_to(int n);
    while (cyc < n) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic edge_at(string tag, int n,
                         logic [3:0] pre, logic [3:0] post);
    step_to(n - 1);
    chk($sformatf("%s_pre@%0d", tag, n), lamps(), pre);
    step_to(n);
    chk($sformatf("%s_post@%0d", tag, n), lamps(), post);
  endtask

  initial begin
    tl_if.congdetector = 1'b0;

    // no congestion
    do_reset();
    edge_at("s1_mg_my", 6000, L_MG, L_MY);
    edge_at("s1_my_sg", 6300, L_MY, L_SG);
    edge_at("s1_sg_sy", 8300, L_SG, L_SY);
    edge_at("s1_sy_mg", 8600, L_SY, L_MG);

    // congestion pulse 40-44 s
    do_reset();
    step_to(4000);
    tl_if.congdetector = 1'b1;
    step_to(4400);
    tl_if.congdetector = 1'b0;
    edge_at("s2_base", 6000, L_MG, L_MG);
    edge_at("s2_mg_my", 9000, L_MG, L_MY);
    edge_at("s2_my_sg", 9300, L_MY, L_SG);
    edge_at("s2_sg_sy", 11300, L_SG, L_SY);
    edge_at("s2_sy_mg", 11600, L_SY, L_MG);

    // congestion held over two main phases
    do_reset();
    tl_if.congdetector = 1'b1;
    edge_at("s3_base1", 6000, L_MG, L_MG);
    edge_at("s3_mg_my1", 9000, L_MG, L_MY);
    edge_at("s3_sy_mg", 11600, L_SY, L_MG);
    edge_at("s3_base2", 17600, L_MG, L_MG);
    edge_at("s3_mg_my2", 20600, L_MG, L_MY);
    tl_if.congdetector = 1'b0;

    // congestion only during side green
    do_reset();
    step_to(7000);
    tl_if.congdetector = 1'b1;
    step_to(7200);
    tl_if.congdetector = 1'b0;
    edge_at("s4_sy_mg", 8600, L_SY, L_MG);
    edge_at("s4_mg_my", 14600, L_MG, L_MY);

    // reset mid side-green
    do_reset();
    step_to(6500);
    chk("s5_sg", lamps(), L_SG);
    #1 rst = 1'b0;
    #1 chk("s5_async", lamps(), L_MG);
    do_reset();
    edge_at("s5_mg_my", 6000, L_MG, L_MY);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trafficlight.md
# trafficlight

Two-road intersection controller: a main road and a side road, each with a 2-bit lamp output. The block cycles main green, main yellow, side green, side yellow on whole-second timers derived from the system clock. A congestion detector input extends the current main-road green once per phase. It sits between the roadside congestion sensor and the lamp drivers.

## Interface
- CLK_HZ, 100: clock frequency; one second equals CLK_HZ cycles.
- MAIN_GREEN_S, 60: base main-green duration in seconds.
- CONG_EXT_S, 30: extra main-green seconds granted when congestion is seen.
- YELLOW_S, 3: yellow duration for either road.
- SIDE_GREEN_S, 20: side-green duration.
- Port order is fixed as MR, SR, congdetector, rst, clk.
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- MR  out  2  main-road lamp.
- SR  out  2  side-road lamp.
- congdetector  in  1  asynchronous congestion flag on the main road; 1 means congested.

## Operation
- Lamp encoding: 2'b00 RED, 2'b01 YELLOW, 2'b10 GREEN. 2'b11 is never driven.
- States and outputs (Moore, decoded from the state register):
  - MAIN_GREEN: MR=GREEN, SR=RED.
  - MAIN_YELLOW: MR=YELLOW, SR=RED.
  - SIDE_GREEN: MR=RED, SR=GREEN.
  - SIDE_YELLOW: MR=RED, SR=YELLOW.
- Transitions use a per-phase elapsed-second counter (sec_cnt):
  - MAIN_GREEN -> MAIN_YELLOW at the tick completing second MAIN_GREEN_S if no extension was granted. If an extension was granted, at the tick completing second MAIN_GREEN_S+CONG_EXT_S.
  - MAIN_YELLOW -> SIDE_GREEN after YELLOW_S seconds.
  - SIDE_GREEN -> SIDE_YELLOW after SIDE_GREEN_S seconds.
  - SIDE_YELLOW -> MAIN_GREEN after YELLOW_S seconds.
- Congestion handling:
  - congdetector passes through a 2-flop synchronizer.
  - Sticky flag cong_seen sets on any cycle in MAIN_GREEN where the synchronized input is 1.
  - cong_seen clears on leaving MAIN_GREEN.
  - Congestion in any other state is ignored and not remembered.
  - At most one extension per main-green phase, however long or often the input is high.
- Simultaneous events: if the synchronized input rises on the same cycle as the base-expiry tick, the extension is granted.
- Reset (rst=0, any time, including mid-phase):
  - State becomes MAIN_GREEN, so MR=GREEN and SR=RED immediately (asynchronous).
  - Prescaler, sec_cnt, cong_seen and synchronizer flops are cleared.

## Timing
- Prescaler counts 0..CLK_HZ-1. A 1-cycle tick is asserted when the count equals CLK_HZ-1.
- sec_cnt increments on each tick and clears to 0 on every state change. The prescaler is not reset on state change; phases are tick-aligned.
- The first tick comes CLK_HZ cycles after reset release. Phase lengths are exact multiples of CLK_HZ cycles.
- The state and the outputs update on the same clock edge as the terminal tick. There is no combinational path from input to output.
- Congestion latency: 2 cycles to synchronize, plus 1 cycle to set cong_seen.
- Widths: the prescaler uses $clog2(CLK_HZ) bits. sec_cnt is wide enough for MAIN_GREEN_S+CONG_EXT_S.

## Structure
- Package trafficlight_pkg holds:
  - The lamp encoding constants RED, YELLOW and GREEN.
  - The 2-bit state enum MAIN_GREEN, MAIN_YELLOW, SIDE_GREEN, SIDE_YELLOW.
- Sub-module sec_tick_gen (parameter CLK_HZ; ports clk, rst, tick) implements the prescaler.
- The FSM, sec_cnt, synchronizer and cong_seen live in the top level.

## Test plan
All times use default parameters, a 10 ms clock, and t=0 at reset release.
- No congestion: MAIN_GREEN for 0–60 s, MAIN_YELLOW for 60–63 s, SIDE_GREEN for 63–83 s, SIDE_YELLOW for 83–86 s, then MAIN_GREEN again at 86 s. Check the exact cycle of each edge.
- Congestion pulse 40–44 s: MAIN_GREEN holds until 90 s, MAIN_YELLOW 90–93 s, SIDE_GREEN 93–113 s, then MAIN_GREEN at 116 s.
- Congestion held high across two consecutive main phases: each main phase lasts exactly 90 s; no double extension occurs.
- Congestion asserted only during SIDE_GREEN (e.g. 70–72 s in the no-congestion cycle): the following MAIN_GREEN lasts the base 60 s.
- Reset pulse at 65 s (during SIDE_GREEN): MR=GREEN and SR=RED immediately. After release, the 60 s main green restarts from zero.
- Legality check throughout all scenarios: MR and SR are never 2'b11, and MR and SR are never both non-RED.
